// File: rtl/hist_pkg.sv
// hist_pkg: histogram RAM state encoding, default sizes and word-address composition
package hist_pkg;

    localparam int HIST_CNT_W     = 8;
    localparam int HIST_BIN_NUM   = 16;
    localparam int HIST_PIXEL_NUM = 200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_OUT,
        ST_DONE
    } hist_state_t;

    // Word address shared by builder and readout: pixel-major, bin-minor
    function automatic logic [31:0] hist_addr(input logic [31:0] pix, input logic [31:0] bin, input logic [31:0] bin_num);
        return pix * bin_num + bin;
    endfunction

endpackage

// File: rtl/hist_peak_tracker.sv
// hist_peak_tracker: per-pixel running maximum over the readout beats, lowest bin wins ties
module hist_peak_tracker
#(
    parameter int BIN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic             i_beat,
    input  logic             i_last,
    input  logic [BIN_W-1:0] i_bin,
    input  logic [CNT_W-1:0] i_data,
    output logic             o_peak_valid,
    output logic [BIN_W-1:0] o_peak_bin,
    output logic [CNT_W-1:0] o_peak_count
);

    logic [CNT_W-1:0] r_max;
    logic [BIN_W-1:0] r_max_bin;
    logic             r_peak_valid;
    logic [BIN_W-1:0] r_peak_bin;
    logic [CNT_W-1:0] r_peak_count;
    logic             w_take;

    assign w_take       = i_data > r_max;
    assign o_peak_valid = r_peak_valid;
    assign o_peak_bin   = r_peak_bin;
    assign o_peak_count = r_peak_count;

    // Update the running max per beat; publish and restart on the pixel's last bin
    always_ff @(posedge i_clk) begin
        if (!i_res) begin
            r_max        <= '0;
            r_max_bin    <= '0;
            r_peak_valid <= 1'b0;
            r_peak_bin   <= '0;
            r_peak_count <= '0;
        end else begin
            r_peak_valid <= i_beat & i_last;
            if (i_beat && i_last) begin
                r_peak_count <= w_take ? i_data : r_max;
                r_peak_bin   <= w_take ? i_bin : r_max_bin;
                r_max        <= '0;
                r_max_bin    <= '0;
            end else if (i_beat && w_take) begin
                r_max     <= i_data;
                r_max_bin <= i_bin;
            end
        end
    end

endmodule

// File: rtl/hist_readout_fsm.sv
// hist_readout_fsm: streams and read-clears one histogram RAM bank; HIST_PEAK_TRACK_EN adds per-pixel peak outputs
module hist_readout_fsm
    import hist_pkg::*;
#(
    parameter  int BIN_NUM   = HIST_BIN_NUM,
    parameter  int CNT_W     = HIST_CNT_W,
    parameter  int PIXEL_NUM = HIST_PIXEL_NUM,
    parameter  int PIX_W     = 8,
    localparam int BIN_W     = $clog2(BIN_NUM),
    localparam int ADDR_W    = PIX_W + BIN_W
) (
    input  logic              i_clk,
    input  logic              i_res,
    input  logic              i_start,
    input  logic              i_bank_sel,
    output logic              o_ram_rd_en,
    output logic              o_ram_bank,
    output logic [ADDR_W-1:0] o_ram_addr,
    input  logic [CNT_W-1:0]  i_ram_rd_data,
    output logic              o_ram_clr_en,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [CNT_W-1:0]  o_m_data,
    output logic [BIN_W-1:0]  o_m_bin,
    output logic [PIX_W-1:0]  o_m_pixel,
    output logic              o_m_last_bin,
    output logic              o_m_last_pixel,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
`ifdef HIST_PEAK_TRACK_EN
    ,
    output logic              o_peak_valid,
    output logic [BIN_W-1:0]  o_peak_bin,
    output logic [CNT_W-1:0]  o_peak_count
`endif
);

    hist_state_t      r_state;
    logic [BIN_W-1:0] r_bin;
    logic [PIX_W-1:0] r_pix;
    logic [CNT_W-1:0] r_data;
    logic             r_bank;
    logic             r_rd_en;
    logic             r_clr_en;
    logic             r_valid;
    logic             r_last_bin;
    logic             r_last_pixel;
    logic             r_busy;
    logic             r_done;
    logic             r_overrun;
    logic             w_fire;
    logic             w_final;

    assign w_fire  = r_valid & i_m_ready;
    assign w_final = (r_pix == PIX_W'(PIXEL_NUM - 1)) && (&r_bin);

    assign o_ram_rd_en    = r_rd_en;
    assign o_ram_bank     = r_bank;
    assign o_ram_addr     = ADDR_W'(hist_addr(32'(r_pix), 32'(r_bin), 32'(BIN_NUM)));
    assign o_ram_clr_en   = r_clr_en;
    assign o_m_valid      = r_valid;
    assign o_m_data       = r_data;
    assign o_m_bin        = r_bin;
    assign o_m_pixel      = r_pix;
    assign o_m_last_bin   = r_last_bin;
    assign o_m_last_pixel = r_last_pixel;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_overrun      = r_overrun;

    // Read, capture-and-clear, then hold the beat until accepted; one bin per pass
    always_ff @(posedge i_clk) begin
        if (!i_res) begin
            r_state      <= ST_IDLE;
            r_bin        <= '0;
            r_pix        <= '0;
            r_data       <= '0;
            r_bank       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_clr_en     <= 1'b0;
            r_valid      <= 1'b0;
            r_last_bin   <= 1'b0;
            r_last_pixel <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= r_overrun | (i_start & r_busy);
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_state <= ST_RD;
                    r_bank  <= i_bank_sel;
                    r_pix   <= '0;
                    r_bin   <= '0;
                    r_rd_en <= 1'b1;
                    r_busy  <= 1'b1;
                end
                ST_RD: begin
                    r_rd_en  <= 1'b0;
                    r_clr_en <= 1'b1;
                    r_state  <= ST_CAP;
                end
                ST_CAP: begin
                    r_clr_en     <= 1'b0;
                    r_data       <= i_ram_rd_data;
                    r_valid      <= 1'b1;
                    r_last_bin   <= &r_bin;
                    r_last_pixel <= w_final;
                    r_state      <= ST_OUT;
                end
                ST_OUT: if (w_fire) begin
                    r_valid <= 1'b0;
                    if (w_final) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_bin   <= r_bin + 1'b1;
                        r_pix   <= (&r_bin) ? r_pix + 1'b1 : r_pix;
                        r_rd_en <= 1'b1;
                        r_state <= ST_RD;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef HIST_PEAK_TRACK_EN
    hist_peak_tracker #(
        .BIN_W (BIN_W),
        .CNT_W (CNT_W)
    ) u_peak (
        .i_clk        (i_clk),
        .i_res        (i_res),
        .i_beat       (w_fire),
        .i_last       (r_last_bin),
        .i_bin        (r_bin),
        .i_data       (r_data),
        .o_peak_valid (o_peak_valid),
        .o_peak_bin   (o_peak_bin),
        .o_peak_count (o_peak_count)
    );
`endif

endmodule

// File: tb/tb_hist_readout_fsm.sv
// tb_hist_readout_fsm: directed checks of stream order, timing, stall, overrun and abort on a 4-bin x 2-pixel RAM
module tb_hist_readout_fsm;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       start = 1'b0;
    logic       bank_sel = 1'b0;
    logic       m_ready = 1'b0;
    logic       rd_en, ram_bank, clr_en, m_valid, last_bin, last_pixel, busy, done, overrun;
    logic [9:0] ram_addr;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] m_data;
    logic [1:0] m_bin;
    logic [7:0] m_pixel;
    logic       ld_en = 1'b0;
    logic       ld_bank = 1'b0;
    logic [2:0] ld_addr = 3'd0;
    logic [7:0] ld_data = 8'h00;
    logic [7:0] mem [2][8];
    int         total = 0;
    int         bad = 0;
`ifdef HIST_PEAK_TRACK_EN
    logic       peak_valid;
    logic [1:0] peak_bin;
    logic [7:0] peak_count;
`endif

    always #5 clk = ~clk;

    hist_readout_fsm #(.BIN_NUM(4), .CNT_W(8), .PIXEL_NUM(2), .PIX_W(8)) dut (
        .i_clk          (clk),
        .i_res          (res),
        .i_start        (start),
        .i_bank_sel     (bank_sel),
        .o_ram_rd_en    (rd_en),
        .o_ram_bank     (ram_bank),
        .o_ram_addr     (ram_addr),
        .i_ram_rd_data  (rd_data),
        .o_ram_clr_en   (clr_en),
        .o_m_valid      (m_valid),
        .i_m_ready      (m_ready),
        .o_m_data       (m_data),
        .o_m_bin        (m_bin),
        .o_m_pixel      (m_pixel),
        .o_m_last_bin   (last_bin),
        .o_m_last_pixel (last_pixel),
        .o_busy         (busy),
        .o_done         (done),
        .o_overrun      (overrun)
`ifdef HIST_PEAK_TRACK_EN
        ,
        .o_peak_valid   (peak_valid),
        .o_peak_bin     (peak_bin),
        .o_peak_count   (peak_count)
`endif
    );

    // Two-bank RAM model: one-cycle read latency, clear-to-zero port, bench preload port
    always @(posedge clk) begin
        if (ld_en) mem[ld_bank][ld_addr] <= ld_data;
        if (clr_en) mem[ram_bank][ram_addr[2:0]] <= 8'h00;
        if (rd_en) rd_data <= mem[ram_bank][ram_addr[2:0]];
    end

    task automatic preload(input logic bk, input logic [7:0] v [8]);
        for (int i = 0; i < 8; i++) begin
            ld_en = 1'b1; ld_bank = bk; ld_addr = 3'(i); ld_data = v[i];
            @(negedge clk);
        end
        ld_en = 1'b0;
    endtask

    task automatic test_reset;
        res = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({rd_en, ram_bank, clr_en, m_valid, last_bin, last_pixel, busy, done, overrun} !== 9'd0) begin
            bad++; $display("FAIL reset_flags got=%b exp=000000000", {rd_en, ram_bank, clr_en, m_valid, last_bin, last_pixel, busy, done, overrun});
        end
        total++;
        if ({ram_addr, m_data, m_bin, m_pixel} !== 28'd0) begin
            bad++; $display("FAIL reset_fields got=%h exp=0", {ram_addr, m_data, m_bin, m_pixel});
        end
        res = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream;
        logic [7:0] v [8];
        int t = 0, beats = 0, rds = 0, t_done = -1;
        for (int i = 0; i < 8; i++) v[i] = 8'(i + 1);
        preload(1'b1, v);
        bank_sel = 1'b1; m_ready = 1'b1; start = 1'b1;
        while (t < 60 && t_done < 0) begin
            @(negedge clk); t++; start = 1'b0;
            if (rd_en) begin
                total++;
                if ({ram_bank, ram_addr} !== {1'b1, 10'(rds)} || t != 1 + 3 * rds) begin
                    bad++; $display("FAIL stream_read%0d got=bank%b addr%0d t%0d exp=bank1 addr%0d t%0d", rds, ram_bank, ram_addr, t, rds, 1 + 3 * rds);
                end
                rds++;
            end
            if (m_valid) begin
                total++;
                if ({m_data, m_pixel, m_bin, last_bin, last_pixel} !== {8'(beats + 1), 8'(beats / 4), 2'(beats % 4), beats % 4 == 3, beats == 7} || t != 3 + 3 * beats) begin
                    bad++; $display("FAIL stream_beat%0d got=d%0d p%0d b%0d lb%b lp%b t%0d exp=d%0d p%0d b%0d lb%b lp%b t%0d", beats, m_data, m_pixel, m_bin, last_bin, last_pixel, t,
                                    beats + 1, beats / 4, beats % 4, beats % 4 == 3, beats == 7, 3 + 3 * beats);
                end
                beats++;
            end
            if (done) t_done = t;
        end
        total++;
        if (beats != 8 || rds != 8 || t_done != 25) begin
            bad++; $display("FAIL stream_count got=beats%0d reads%0d done_t%0d exp=beats8 reads8 done_t25", beats, rds, t_done);
        end
        @(negedge clk);
        total++;
        if ({done, busy, overrun} !== 3'b000) begin
            bad++; $display("FAIL stream_idle got=done%b busy%b ovr%b exp=000", done, busy, overrun);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (mem[1][i] !== 8'h00) begin
                bad++; $display("FAIL stream_clear%0d got=%h exp=00", i, mem[1][i]);
            end
        end
    endtask

    task automatic test_stall;
        logic [7:0] v [8];
        logic [17:0] snap = '0;
        int t = 0, beats = 0, rds = 0, stall = 0;
        logic seen = 1'b0;
        v = '{8'h11, 8'h00, 8'h33, 8'hFF, 8'h00, 8'h66, 8'h77, 8'h80};
        preload(1'b0, v);
        bank_sel = 1'b0; m_ready = 1'b0; start = 1'b1;
        while (t < 100 && !seen) begin
            @(negedge clk); t++; start = 1'b0;
            if (rd_en) rds++;
            if (m_valid && beats == 2 && stall < 5) begin
                m_ready = 1'b0;
                if (stall == 0) snap = {m_data, m_pixel, m_bin};
                else begin
                    total++;
                    if ({m_data, m_pixel, m_bin} !== snap) begin
                        bad++; $display("FAIL stall_hold%0d got=%h exp=%h", stall, {m_data, m_pixel, m_bin}, snap);
                    end
                end
                stall++;
            end else if (m_valid) begin
                m_ready = 1'b1;
                total++;
                if ({m_data, m_pixel, m_bin} !== {v[beats], 8'(beats / 4), 2'(beats % 4)}) begin
                    bad++; $display("FAIL stall_beat%0d got=%h exp=%h", beats, {m_data, m_pixel, m_bin}, {v[beats], 8'(beats / 4), 2'(beats % 4)});
                end
                beats++;
            end else m_ready = 1'b0;
            if (done) seen = 1'b1;
        end
        total++;
        if (beats != 8 || rds != 8 || stall != 5 || !seen) begin
            bad++; $display("FAIL stall_count got=beats%0d reads%0d stalls%0d done%b exp=beats8 reads8 stalls5 done1", beats, rds, stall, seen);
        end
        @(negedge clk);
        total++;
        if ({mem[0][0], mem[0][3], mem[0][7]} !== 24'h0) begin
            bad++; $display("FAIL stall_clear got=%h exp=000000", {mem[0][0], mem[0][3], mem[0][7]});
        end
    endtask

    task automatic test_overrun;
        logic [7:0] v [8];
        int t = 0, beats = 0;
        logic seen = 1'b0;
        for (int i = 0; i < 8; i++) v[i] = 8'(i * 3 + 2);
        preload(1'b1, v);
        bank_sel = 1'b1; m_ready = 1'b1; start = 1'b1;
        while (t < 60 && !seen) begin
            @(negedge clk); t++; start = 1'b0;
            if (m_valid) begin
                if (beats == 1) start = 1'b1;
                total++;
                if (m_data !== v[beats]) begin
                    bad++; $display("FAIL overrun_beat%0d got=%h exp=%h", beats, m_data, v[beats]);
                end
                beats++;
            end
            if (done) seen = 1'b1;
        end
        total++;
        if (beats != 8 || !seen || overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_stream got=beats%0d done%b ovr%b exp=beats8 done1 ovr1", beats, seen, overrun);
        end
        repeat (3) @(negedge clk);
        total++;
        if ({overrun, busy, m_valid} !== 3'b100) begin
            bad++; $display("FAIL overrun_sticky got=%b exp=100", {overrun, busy, m_valid});
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] v [8];
        int t = 0, rds = 0;
        logic hit = 1'b0;
        for (int i = 0; i < 8; i++) v[i] = 8'(8'h41 + i);
        preload(1'b0, v);
        bank_sel = 1'b0; m_ready = 1'b1; start = 1'b1;
        while (t < 60 && !hit) begin
            @(negedge clk); t++; start = 1'b0;
            if (rd_en) begin
                if (rds == 4) begin res = 1'b0; hit = 1'b1; end
                rds++;
            end
        end
        @(negedge clk);
        res = 1'b1;
        total++;
        if ({hit, m_valid, busy, rd_en, clr_en, overrun, done} !== 7'b1000000 || {m_pixel, m_bin} !== 10'd0) begin
            bad++; $display("FAIL abort_state got=hit%b v%b busy%b rd%b clr%b ovr%b done%b pix%0d bin%0d exp=hit1 all0",
                            hit, m_valid, busy, rd_en, clr_en, overrun, done, m_pixel, m_bin);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (mem[0][i] !== (i < 4 ? 8'h00 : v[i])) begin
                bad++; $display("FAIL abort_ram%0d got=%h exp=%h", i, mem[0][i], i < 4 ? 8'h00 : v[i]);
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if ({m_valid, busy, rd_en} !== 3'b000) begin
            bad++; $display("FAIL abort_quiet got=%b exp=000", {m_valid, busy, rd_en});
        end
    endtask

`ifdef HIST_PEAK_TRACK_EN
    task automatic test_peak;
        logic [7:0] v [8];
        logic [9:0] exp_pk [2];
        int t = 0, lb_t = -10, pulses = 0;
        logic seen = 1'b0;
        v = '{8'd3, 8'd9, 8'd9, 8'd2, 8'd1, 8'd4, 8'd8, 8'd8};
        exp_pk = '{{2'd1, 8'd9}, {2'd2, 8'd8}};
        preload(1'b0, v);
        bank_sel = 1'b0; m_ready = 1'b1; start = 1'b1;
        while (t < 60 && !seen) begin
            @(negedge clk); t++; start = 1'b0;
            if (peak_valid) begin
                total++;
                if (pulses > 1 || {peak_bin, peak_count} !== exp_pk[pulses & 1] || t != lb_t + 1) begin
                    bad++; $display("FAIL peak%0d got=bin%0d cnt%0d t%0d exp=bin%0d cnt%0d t%0d", pulses, peak_bin, peak_count, t,
                                    exp_pk[pulses & 1][9:8], exp_pk[pulses & 1][7:0], lb_t + 1);
                end
                pulses++;
            end
            if (m_valid && last_bin) lb_t = t;
            if (done) seen = 1'b1;
        end
        total++;
        if (pulses != 2 || !seen) begin
            bad++; $display("FAIL peak_count got=pulses%0d done%b exp=pulses2 done1", pulses, seen);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset;
        test_stream;
        test_stall;
        test_overrun;
        test_reset_mid;
`ifdef HIST_PEAK_TRACK_EN
        test_peak;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
